tdd_edge_capture: RTL and testbench
===================================

# tdd_edge_capture

Receive-side timing monitor for the TDD engine: samples the TDD channel outputs and the frame sync pulse, measures each channel's rising and falling edge offsets in clock cycles from the start of the frame, and streams one record per edge through a valid/ready FIFO. It sits in the `clk` domain next to the TDD engine, or at a remote endpoint that receives its channel lines. It allows on/off timing to be read back and checked against the programmed values.

## Interface
- `CHANNEL_COUNT`, 8: number of monitored channels, 1..32.
- `REGISTER_WIDTH`, 32: offset counter width, the same width as the engine's timing registers.
- `FIFO_DEPTH`, 16: number of record FIFO entries; must be a power of 2, at least 2.
- Derived: `CH_W = max(1, $clog2(CHANNEL_COUNT))`; `DATA_W = REGISTER_WIDTH + CH_W + 2`.
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: monitor enable, level-sensitive.
- `sync_in` in 1: frame-start pulse, one `clk` wide, synchronous to `clk`.
- `tdd_channel` in CHANNEL_COUNT: monitored channel levels, synchronous to `clk`.
- `m_valid` out 1: record available.
- `m_ready` in 1: consumer accepts the record.
- `m_data` out DATA_W: record, fields from MSB to LSB:
  - `marker` (1 bit)
  - `edge` (1 bit: 1 = rising, 0 = falling)
  - `channel` (CH_W bits)
  - `offset` (REGISTER_WIDTH bits)
- `frame_count` out 32: number of sync pulses received since the monitor was armed.
- `overflow` out 1: sticky flag; at least one edge was lost.
- `active` out 1: high in state RUN.

## Operation
- States:
  - IDLE: `enable` = 0.
  - ARMED: `enable` = 1, no sync received yet.
  - RUN: frames are being measured.
- Transitions:
  - IDLE → ARMED when `enable` = 1. On entry, `overflow`, `frame_count`, all pending slots and the FIFO are cleared.
  - ARMED → RUN on `sync_in`.
  - Any state → IDLE on `enable` = 0, effective next cycle. Slots and FIFO are flushed, `m_valid` is 0, and `frame_count`/`overflow` hold their values.
- `tdd_channel` is registered once into `cur`, with `prev` one stage behind. `prev` updates in every state, so entering RUN never produces a false edge. Edge vector = `cur ^ prev`; the `edge` bit = the `cur` bit.
- Offset counter:
  - The `sync_in` sample defines offset 0.
  - An edge whose new level first appears in `cur` N cycles after that sync sample reports offset N.
  - An edge coinciding with sync reports offset 0 and belongs to the new frame.
  - The counter saturates at 2^REGISTER_WIDTH−1; there is no wrap.
- Edges in IDLE or ARMED are discarded.
- Each channel has one pending slot holding {edge, offset}.
  - A detected edge loads the slot.
  - If the slot is still occupied, the new edge is dropped and `overflow` is set. The older record is kept.
- Arbiter:
  - Moves at most one pending slot per cycle into the FIFO, only when the FIFO is not full.
  - Priority: marker slot (see Configuration) first, then the lowest channel index.
  - A slot that is drained and loaded in the same cycle takes the new edge, with no overflow.
- FIFO full: slots hold their contents (backpressure). Loss occurs only through slot collision.
- `frame_count` increments on every `sync_in` in ARMED or RUN, and wraps modulo 2^32.
- `marker` is 0 in every channel record.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `frame_count` = 0, `overflow` = 0, `active` = 0.
  - State IDLE, counter 0, `cur`/`prev` = 0.
- Latency from edge to output: the channel changes before clock edge k and is in `cur` after k. The slot loads at k+1, the FIFO write happens at k+2, and `m_valid` = 1 after k+2, assuming no contention and an empty FIFO.
- Handshake:
  - A transfer occurs when `m_valid` & `m_ready`.
  - `m_data` is stable while `m_valid` = 1 and `m_ready` = 0.
  - `m_valid` never drops without a transfer, except on disable or reset.
- The FIFO sustains one write and one read per cycle when full, provided `m_ready` = 1.
- `active` rises one cycle after the `sync_in` sample that leaves ARMED.
- `overflow` rises the cycle after the colliding edge is detected.
- Asynchronous reset mid-frame: all state clears immediately and no partial record is emitted.

## Configuration
- `TDD_EDGE_CAPTURE_SYNC_MARK_EN`
  - Defined: every `sync_in` in RUN loads a marker slot with `marker` = 1, `edge` = 1, `channel` = 0, and `offset` = the counter value just before the sync (the previous frame length, saturated). This marker slot has highest arbiter priority. If the marker slot is still occupied, the new marker is dropped and `overflow` is set. The first sync (ARMED → RUN) produces no marker.
  - Undefined: the marker slot logic is absent and `marker` is constant 0.

## Test plan
- `enable` = 1, `m_ready` = 1, sync at t0, ch0 rises at t0+10 and falls at t0+50 → records {0,1,0,10} then {0,0,0,50}; `frame_count` = 1.
- Channels 0, 3 and 5 rise in the same cycle, offset 7 → three records in the order ch0, ch3, ch5, each with offset 7, on consecutive cycles.
- `m_ready` = 0, 20 edges on ch1 spaced 4 cycles apart, FIFO_DEPTH = 16 → exactly 17 records retained (16 in the FIFO plus 1 in the slot); `overflow` = 1; later records appear in order once `m_ready` = 1.
- Edge while ARMED, then `enable` dropped mid-frame with 3 records queued → no ARMED record; `m_valid` = 0 the next cycle; `frame_count` held.
- REGISTER_WIDTH = 4, edge at 20 cycles after sync → offset 15 (saturated). Sync plus a simultaneous ch2 rise → offset 0.
- With the macro defined: two syncs 100 cycles apart → marker record {1,1,0,99} precedes any channel record of the second frame.

Source files
------------

// File: rtl/tdd_edge_capture.sv
// tdd_edge_capture: receive-side TDD timing monitor.
// Samples the channel lines and the frame sync pulse, measures per-channel
// rising/falling edge offsets from the frame start and streams one record
// per edge through a valid/ready FIFO.
// Record layout (MSB..LSB): {marker, edge, channel[CH_W], offset[REGISTER_WIDTH]}.
// Optional feature macro: TDD_EDGE_CAPTURE_SYNC_MARK_EN adds a marker record
// carrying the previous frame length on every sync received while running.
module tdd_edge_capture #(
    parameter int unsigned CHANNEL_COUNT  = 8,
    parameter int unsigned REGISTER_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 16,
    localparam int unsigned CH_W   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int unsigned DATA_W = REGISTER_WIDTH + CH_W + 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     sync_in,
    input  logic [CHANNEL_COUNT-1:0] tdd_channel,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [31:0]              frame_count,
    output logic                     overflow,
    output logic                     active
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [REGISTER_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN
    } state_e;

    state_e state_q, state_d;

    logic [REGISTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNEL_COUNT-1:0]  cur_q, prev_q;
    logic [CHANNEL_COUNT-1:0]  edges;

    logic [CHANNEL_COUNT-1:0]  slot_vld_q, slot_vld_d;
    logic [CHANNEL_COUNT-1:0]  slot_edge_q, slot_edge_d;
    logic [REGISTER_WIDTH-1:0] slot_off_q [CHANNEL_COUNT];
    logic [REGISTER_WIDTH-1:0] slot_off_d [CHANNEL_COUNT];

`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
    logic                      mk_vld_q, mk_vld_d;
    logic [REGISTER_WIDTH-1:0] mk_off_q, mk_off_d;
`endif

    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic        ovf_q, ovf_d;
    logic        ovf_set;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              fifo_full, fifo_empty;

    logic                      flush, clear, run, sync_ev;
    logic                      rd_fire, can_wr, wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      sel_mk, sel_ch_vld;
    logic [CH_W-1:0]           sel_idx;
    logic                      sel_edge;
    logic [REGISTER_WIDTH-1:0] sel_off;
    logic [CHANNEL_COUNT-1:0]  drain_vec;

    // Control qualifiers: disable flushes, IDLE->ARMED entry clears everything.
    assign flush   = !enable;
    assign clear   = enable && (state_q == S_IDLE);
    assign run     = enable && (state_q == S_RUN);
    assign sync_ev = enable && sync_in && (state_q != S_IDLE);
    assign edges   = cur_q ^ prev_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign m_valid     = !fifo_empty;
    assign m_data      = m_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign rd_fire     = m_valid && m_ready;
    // A read in the same cycle frees a place, so a full FIFO still accepts a write.
    assign can_wr      = !fifo_full || rd_fire;
    assign frame_count = frame_cnt_q;
    assign overflow    = ovf_q;
    assign active      = (state_q == S_RUN);

    // Next-state logic for the monitor FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_ARMED;
            S_ARMED: if (sync_in) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;
    end

    // State, input sampling and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= tdd_channel;
            prev_q      <= cur_q;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Offset counter (restarts on sync, saturates) and frame/overflow status.
    always_comb begin
        cnt_d = cnt_q;
        if (flush || clear) begin
            cnt_d = '0;
        end else if (sync_ev) begin
            cnt_d = '0;
        end else if ((state_q == S_RUN) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + REGISTER_WIDTH'(1);
        end

        frame_cnt_d = frame_cnt_q;
        if (clear) begin
            frame_cnt_d = '0;
        end else if (sync_ev) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
        end

        ovf_d = clear ? 1'b0 : (ovf_q | ovf_set);
    end

    // Arbiter: marker slot first, then lowest channel index, one per cycle.
    always_comb begin
        sel_mk     = 1'b0;
        sel_ch_vld = 1'b0;
        sel_idx    = '0;
        sel_edge   = 1'b0;
        sel_off    = '0;
        drain_vec  = '0;
`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
        sel_mk = can_wr && mk_vld_q;
`endif
        for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            if (can_wr && !sel_mk && !sel_ch_vld && slot_vld_q[i]) begin
                sel_ch_vld   = 1'b1;
                sel_idx      = CH_W'(i);
                sel_edge     = slot_edge_q[i];
                sel_off      = slot_off_q[i];
                drain_vec[i] = 1'b1;
            end
        end
        wr_en   = sel_mk || sel_ch_vld;
        wr_data = {1'b0, sel_edge, sel_idx, sel_off};
`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
        if (sel_mk) wr_data = {1'b1, 1'b1, {CH_W{1'b0}}, mk_off_q};
`endif
    end

    // Pending slots: load on edge in RUN, drop and flag when still occupied.
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_edge_d = slot_edge_q;
        slot_off_d  = slot_off_q;
        ovf_set     = 1'b0;
        for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
            if (drain_vec[i]) slot_vld_d[i] = 1'b0;
            if (run && edges[i]) begin
                // A slot drained this cycle is free for the new edge.
                if (slot_vld_q[i] && !drain_vec[i]) begin
                    ovf_set = 1'b1;
                end else begin
                    slot_vld_d[i]  = 1'b1;
                    slot_edge_d[i] = cur_q[i];
                    slot_off_d[i]  = cnt_q;
                end
            end
        end
`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
        mk_vld_d = mk_vld_q;
        mk_off_d = mk_off_q;
        if (sel_mk) mk_vld_d = 1'b0;
        if (run && sync_in) begin
            if (mk_vld_q && !sel_mk) begin
                ovf_set = 1'b1;
            end else begin
                mk_vld_d = 1'b1;
                mk_off_d = cnt_q;
            end
        end
        if (flush || clear) mk_vld_d = 1'b0;
`endif
        if (flush || clear) slot_vld_d = '0;
    end

    // Slot registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_vld_q  <= '0;
            slot_edge_q <= '0;
            for (int unsigned i = 0; i < CHANNEL_COUNT; i++) slot_off_q[i] <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_edge_q <= slot_edge_d;
            slot_off_q  <= slot_off_d;
        end
    end

`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
    // Marker slot register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mk_vld_q <= 1'b0;
            mk_off_q <= '0;
        end else begin
            mk_vld_q <= mk_vld_d;
            mk_off_q <= mk_off_d;
        end
    end
`endif

    // FIFO pointer next-state; disable and arming both empty the FIFO.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush || clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en)   wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; output is gated by m_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_tdd_edge_capture.sv
// Directed self-checking bench for tdd_edge_capture (default build, plus
// marker checks when TDD_EDGE_CAPTURE_SYNC_MARK_EN is defined). A second
// instance with REGISTER_WIDTH = 4 shares the stimulus for saturation checks.
module tb_tdd_edge_capture;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        sync_in;
    logic [7:0]  tdd_channel;
    logic        m_ready;
    logic        m_valid;
    logic [36:0] m_data;
    logic [31:0] frame_count;
    logic        overflow;
    logic        active;

    logic        s_m_ready;
    logic        s_m_valid;
    logic [8:0]  s_m_data;
    logic [31:0] s_frame_count;
    logic        s_overflow;
    logic        s_active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s_cyc    = 0;

    logic [36:0] q[$];
    int          qc[$];
    logic [8:0]  qs[$];

    always #5 clk = ~clk;

    tdd_edge_capture u_dut (
        .clk(clk), .resetn(resetn), .enable(enable), .sync_in(sync_in),
        .tdd_channel(tdd_channel), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .frame_count(frame_count), .overflow(overflow),
        .active(active)
    );

    tdd_edge_capture #(.REGISTER_WIDTH(4)) u_dut_sat (
        .clk(clk), .resetn(resetn), .enable(enable), .sync_in(sync_in),
        .tdd_channel(tdd_channel), .m_valid(s_m_valid), .m_ready(s_m_ready),
        .m_data(s_m_data), .frame_count(s_frame_count), .overflow(s_overflow),
        .active(s_active)
    );

    // Record every accepted transfer, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            q.push_back(m_data);
            qc.push_back(cyc);
        end
        if (s_m_valid && s_m_ready) qs.push_back(s_m_data);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [36:0] rec(input logic m, input logic e,
                                        input logic [2:0] ch, input logic [31:0] off);
        return {m, e, ch, off};
    endfunction

    function automatic logic [8:0] rec_s(input logic m, input logic e,
                                         input logic [2:0] ch, input logic [3:0] off);
        return {m, e, ch, off};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    // Sync sampled on the next edge; that edge becomes offset 0.
    task automatic sync_pulse();
        sync_in = 1'b1;
        step(1);
        sync_in = 1'b0;
        s_cyc = cyc;
    endtask

    // Advance so that an input changed now is sampled at offset n.
    task automatic goto_off(input int n);
        while (cyc < s_cyc + n - 1) step(1);
    endtask

    task automatic pop_check(input string tag, input logic [36:0] exp);
        logic [36:0] got;
        got = (q.size() > 0) ? q.pop_front() : '0;
        check(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        int c0, c1, c2;
        logic [8:0] sv;
        resetn = 1'b0; enable = 1'b0; sync_in = 1'b0; tdd_channel = '0;
        m_ready = 1'b0; s_m_ready = 1'b1;
        step(2);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_frames", 64'(frame_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        resetn = 1'b1;
        step(1);

        // Basic rise/fall on ch0 with latency check.
        enable = 1'b1; m_ready = 1'b1;
        step(2);
        check("armed_active", 64'(active), 64'd0);
        sync_pulse();
        check("run_active", 64'(active), 64'd1);
        goto_off(10); tdd_channel[0] = 1'b1;
        step(2);
        check("lat_k1", 64'(m_valid), 64'd0);
        step(1);
        check("lat_k2", 64'(m_valid), 64'd1);
        goto_off(50); tdd_channel[0] = 1'b0;
        step(6);
        check("t1_count", 64'(q.size()), 64'd2);
        pop_check("t1_rise", rec(1'b0, 1'b1, 3'd0, 32'd10));
        pop_check("t1_fall", rec(1'b0, 1'b0, 3'd0, 32'd50));
        check("t1_frames", 64'(frame_count), 64'd1);
        q.delete(); qc.delete();

        // Three simultaneous edges, drained in index order on consecutive cycles.
        sync_pulse();
        goto_off(7); tdd_channel = 8'b0010_1001;
        goto_off(14);
`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
        check("t2_count", 64'(q.size()), 64'd4);
        begin
            logic [36:0] mk;
            mk = (q.size() > 0) ? q.pop_front() : '0;
            void'(qc.pop_front());
            check("t2_marker_bits", 64'(mk[36:32]), 64'b11000);
        end
`else
        check("t2_count", 64'(q.size()), 64'd3);
`endif
        c0 = (qc.size() > 0) ? qc.pop_front() : 0;
        c1 = (qc.size() > 0) ? qc.pop_front() : 0;
        c2 = (qc.size() > 0) ? qc.pop_front() : 0;
        pop_check("t2_ch0", rec(1'b0, 1'b1, 3'd0, 32'd7));
        pop_check("t2_ch3", rec(1'b0, 1'b1, 3'd3, 32'd7));
        pop_check("t2_ch5", rec(1'b0, 1'b1, 3'd5, 32'd7));
        check("t2_consec_a", 64'(c1 - c0), 64'd1);
        check("t2_consec_b", 64'(c2 - c1), 64'd1);
        check("t2_frames", 64'(frame_count), 64'd2);
        enable = 1'b0; tdd_channel = '0;
        step(3);
        check("dis_valid", 64'(m_valid), 64'd0);
        check("dis_frames", 64'(frame_count), 64'd2);
        q.delete(); qc.delete();

        // Backpressure: 20 edges on ch1 with m_ready low.
        enable = 1'b1; m_ready = 1'b0;
        step(2);
        check("rearm_frames", 64'(frame_count), 64'd0);
        sync_pulse();
        for (int i = 0; i < 20; i++) begin
            goto_off(4 * (i + 1));
            tdd_channel[1] = ~tdd_channel[1];
        end
        step(10);
        check("bp_ovf", 64'(overflow), 64'd1);
        check("bp_none", 64'(q.size()), 64'd0);
        check("bp_hold", 64'(m_data), 64'(rec(1'b0, 1'b1, 3'd1, 32'd4)));
        m_ready = 1'b1;
        step(25);
        check("bp_count", 64'(q.size()), 64'd17);
        for (int i = 0; i < 17; i++) begin
            pop_check($sformatf("bp_rec%0d", i),
                      rec(1'b0, (i % 2 == 0), 3'd1, 32'(4 * (i + 1))));
        end
        check("bp_drained", 64'(m_valid), 64'd0);

        // Edge in ARMED is ignored; disable mid-frame flushes queued records.
        enable = 1'b0;
        step(2);
        q.delete(); qc.delete();
        enable = 1'b1;
        step(2);
        tdd_channel[1] = 1'b1;
        step(5);
        check("armed_none", 64'(q.size()), 64'd0);
        m_ready = 1'b0;
        sync_pulse();
        check("t4_frames", 64'(frame_count), 64'd1);
        goto_off(3); tdd_channel[1] = 1'b0;
        goto_off(6); tdd_channel[1] = 1'b1;
        goto_off(9); tdd_channel[1] = 1'b0;
        goto_off(15);
        check("t4_queued", 64'(m_valid), 64'd1);
        enable = 1'b0;
        step(1);
        check("t4_flush_valid", 64'(m_valid), 64'd0);
        check("t4_flush_active", 64'(active), 64'd0);
        m_ready = 1'b1;
        step(4);
        check("t4_no_rec", 64'(q.size()), 64'd0);
        check("t4_frames_hold", 64'(frame_count), 64'd1);

        // Sync with coincident ch2 rise -> offset 0; saturation on the narrow instance.
        q.delete(); qc.delete(); qs.delete();
        enable = 1'b1;
        step(2);
        tdd_channel[2] = 1'b1;
        sync_pulse();
        goto_off(20); tdd_channel[2] = 1'b0;
        step(6);
        check("t5_count", 64'(q.size()), 64'd2);
        pop_check("t5_zero", rec(1'b0, 1'b1, 3'd2, 32'd0));
        pop_check("t5_wide20", rec(1'b0, 1'b0, 3'd2, 32'd20));
        check("sat_count", 64'(qs.size()), 64'd2);
        sv = (qs.size() > 0) ? qs.pop_front() : '0;
        check("sat_zero", 64'(sv), 64'(rec_s(1'b0, 1'b1, 3'd2, 4'd0)));
        sv = (qs.size() > 0) ? qs.pop_front() : '0;
        check("sat_15", 64'(sv), 64'(rec_s(1'b0, 1'b0, 3'd2, 4'd15)));

`ifdef TDD_EDGE_CAPTURE_SYNC_MARK_EN
        // Two syncs 100 cycles apart: marker with previous frame length first.
        enable = 1'b0; tdd_channel = '0;
        step(2);
        q.delete(); qc.delete();
        enable = 1'b1;
        step(2);
        sync_pulse();
        goto_off(100);
        tdd_channel[3] = 1'b1;
        sync_pulse();
        step(6);
        check("mk_count", 64'(q.size()), 64'd2);
        pop_check("mk_marker", rec(1'b1, 1'b1, 3'd0, 32'd99));
        pop_check("mk_ch3", rec(1'b0, 1'b1, 3'd3, 32'd0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
